// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the uart_tx_sched scheduler.
// UART_SCHED_TAG_EN adds the TAG state used to prefix packets with an id byte.
package uart_sched_pkg;

  localparam int MaxReq = 8;

  // Low three bits of TagBase are reserved for the requester id.
  localparam logic [7:0] TagMask = 8'hF8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
`ifdef UART_SCHED_TAG_EN
    ST_TAG     = 3'd1,
`endif
    ST_LOAD    = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_WAIT_LO = 3'd5
  } state_t;

  function automatic int idxWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set bit of i_valid searching
// upward from i_ptr+1, wrapping modulo N.
module rr_pick #(
  parameter int N    = 4,
  parameter int IdxW = 2
) (
  input  logic [N-1:0]    i_valid,
  input  logic [IdxW-1:0] i_ptr,
  output logic [N-1:0]    o_grant,
  output logic [IdxW-1:0] o_idx,
  output logic            o_any
);

  logic [IdxW-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IdxW'((int'(i_ptr) + k) % N);
      if (!o_any && i_valid[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between NumReq byte-stream requesters.
// Define UART_SCHED_TAG_EN to prefix every packet with the tag byte TagBase|id.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int         NumReq  = 4,
  parameter logic [7:0] TagBase = 8'hA0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NumReq-1:0]     i_req_valid,
  input  logic [NumReq*8-1:0]   i_req_data,
  input  logic [NumReq-1:0]     i_req_last,
  output logic [NumReq-1:0]     o_req_ready,
  output logic [NumReq-1:0]     o_grant,
  output logic                  o_tx_enable,
  output logic [7:0]            o_tx_data,
  input  logic                  i_tx_busy,
  output logic                  o_busy
);

  localparam int IdxW = idxWidth(NumReq);

  state_t            r_state;
  state_t            w_stateNext;
  logic [NumReq-1:0] r_grant;
  logic [IdxW-1:0]   r_idx;
  logic [IdxW-1:0]   r_ptr;
  logic              r_lastQ;
  logic [7:0]        r_txData;

  logic [NumReq-1:0] w_pickGrant;
  logic [IdxW-1:0]   w_pickIdx;
  logic              w_pickAny;
  logic              w_handshake;
  logic              w_ownLast;
  logic [7:0]        w_ownData;
  logic              w_sentTag;

  rr_pick #(
    .N    (NumReq),
    .IdxW (IdxW)
  ) u_pick (
    .i_valid (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_pickGrant),
    .o_idx   (w_pickIdx),
    .o_any   (w_pickAny)
  );

  // Ready depends on state and grant only, so a producer may wait on it.
  assign o_req_ready = r_grant & {NumReq{r_state == ST_LOAD}};
  assign w_handshake = |(i_req_valid & o_req_ready);

  always_comb begin
    w_ownData = '0;
    w_ownLast = 1'b0;
    for (int r = 0; r < NumReq; r++) begin
      if (r_grant[r]) begin
        w_ownData = i_req_data[8*r +: 8];
        w_ownLast = i_req_last[r];
      end
    end
  end

`ifdef UART_SCHED_TAG_EN
  logic       r_tagSent;
  logic [7:0] w_tagByte;

  assign w_tagByte = (TagBase & TagMask) | 8'(r_idx);
  assign w_sentTag = r_tagSent;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tagSent <= 1'b0;
    end else if (r_state == ST_TAG) begin
      r_tagSent <= 1'b1;
    end else if (r_state == ST_LOAD && w_handshake) begin
      r_tagSent <= 1'b0;
    end
  end
`else
  logic [7:0] w_unusedTagBase;

  assign w_unusedTagBase = TagBase;
  assign w_sentTag       = 1'b0;
`endif

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: begin
        // Never start while a frame is still leaving uart_tx (e.g. after reset).
        if (!i_tx_busy && w_pickAny) begin
`ifdef UART_SCHED_TAG_EN
          w_stateNext = ST_TAG;
`else
          w_stateNext = ST_LOAD;
`endif
        end
      end
`ifdef UART_SCHED_TAG_EN
      ST_TAG:     w_stateNext = ST_SEND;
`endif
      ST_LOAD: begin
        if (w_handshake) w_stateNext = ST_SEND;
      end
      ST_SEND:    w_stateNext = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (i_tx_busy) w_stateNext = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!i_tx_busy) begin
          if (r_lastQ && !w_sentTag) w_stateNext = ST_IDLE;
          else                       w_stateNext = ST_LOAD;
        end
      end
      default:    w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_stateNext;
  end

  // Grant, pointer and the byte register only move at packet boundaries or loads.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant  <= '0;
      r_idx    <= '0;
      r_ptr    <= IdxW'(NumReq - 1);
      r_lastQ  <= 1'b0;
      r_txData <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_stateNext != ST_IDLE) begin
            r_grant <= w_pickGrant;
            r_idx   <= w_pickIdx;
          end
        end
`ifdef UART_SCHED_TAG_EN
        ST_TAG: r_txData <= w_tagByte;
`endif
        ST_LOAD: begin
          if (w_handshake) begin
            r_txData <= w_ownData;
            r_lastQ  <= w_ownLast;
          end
        end
        ST_WAIT_LO: begin
          if (!i_tx_busy && r_lastQ && !w_sentTag) begin
            r_grant <= '0;
            r_ptr   <= r_idx;
            r_lastQ <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_grant     = r_grant;
  assign o_tx_enable = (r_state == ST_SEND);
  assign o_tx_data   = r_txData;
  assign o_busy      = (r_state != ST_IDLE);

endmodule
